// File: rtl/mem_stage.sv
// Memory pipeline stage between ex_mem and mem_wb: non-memory ops pass through in one cycle, LW/SW handshake with data memory.
// Optional build macro MEM_TIMEOUT_EN adds a 16-cycle access timeout with a sticky err_o flag.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] alu_data_i,
  input  logic [3:0]  rd_i,
  input  logic [3:0]  op_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_o,
  output logic        valid_o,
  output logic        wb_en_o,
  output logic [3:0]  wb_rd_o,
  output logic [15:0] wb_data_o,
  output logic        err_o
);

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  function automatic logic writes_reg(input logic [3:0] op);
    return !((op == OP_SW) || (op == OP_B) || (op == OP_BR) || (op == OP_HLT));
  endfunction

  state_t      state_r;
  logic [3:0]  op_r;
  logic [3:0]  rd_r;
  logic        is_mem_s;
  logic        stall_s;
  logic        timeout_s;

  assign is_mem_s = (op_i == OP_LW) || (op_i == OP_SW);

`ifdef MEM_TIMEOUT_EN
  logic [3:0] cnt_r;

  assign timeout_s = (cnt_r == 4'd15) && !dmem_ack;

  // Access-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
      err_o <= 1'b0;
    end else begin
      if (state_r == IDLE) begin
        cnt_r <= 4'd0;
      end else if (!dmem_ack) begin
        cnt_r <= cnt_r + 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if ((state_r == ACCESS) && timeout_s) begin
        err_o <= 1'b1;
      end else begin
        err_o <= err_o;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Upstream hold: accepting a memory op, or waiting for the memory acknowledge.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = valid_i && is_mem_s;
      ACCESS:  stall_s = !dmem_ack;
      default: stall_s = 1'b0;
    endcase
  end

  assign stall_o = stall_s;

  // Stage FSM with registered memory request and writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      op_r       <= 4'd0;
      rd_r       <= 4'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 16'd0;
      dmem_wdata <= 16'd0;
      valid_o    <= 1'b0;
      wb_en_o    <= 1'b0;
      wb_rd_o    <= 4'd0;
      wb_data_o  <= 16'd0;
    end else begin
      valid_o <= 1'b0;
      wb_en_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid_i && is_mem_s) begin
            state_r    <= ACCESS;
            op_r       <= op_i;
            rd_r       <= rd_i;
            dmem_req   <= 1'b1;
            dmem_we    <= (op_i == OP_SW);
            dmem_addr  <= mem_addr_i & 16'hFFFE;
            dmem_wdata <= alu_data_i;
          end else if (valid_i) begin
            valid_o   <= 1'b1;
            wb_en_o   <= writes_reg(op_i);
            wb_rd_o   <= rd_i;
            wb_data_o <= alu_data_i;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state_r    <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wdata <= 16'd0;
            valid_o    <= 1'b1;
            wb_en_o    <= writes_reg(op_r);
            wb_rd_o    <= rd_r;
            // dmem_wdata still holds the captured store data here.
            wb_data_o  <= (op_r == OP_LW) ? dmem_rdata : dmem_wdata;
          end else if (timeout_s) begin
            state_r    <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wdata <= 16'd0;
            valid_o    <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage; expectations come from the stage's behavioural rules.
module tb_mem_stage;

  localparam logic [3:0] LW  = 4'b1000;
  localparam logic [3:0] SW  = 4'b1001;
  localparam logic [3:0] ADD = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [15:0] mem_addr_i = 16'd0;
  logic [15:0] alu_data_i = 16'd0;
  logic [3:0]  rd_i = 4'd0;
  logic [3:0]  op_i = 4'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = 16'd0;
  logic        dmem_ack = 1'b0;
  logic        stall_o;
  logic        valid_o;
  logic        wb_en_o;
  logic [3:0]  wb_rd_o;
  logic [15:0] wb_data_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0]  last_rd = 4'd0;
  logic [15:0] last_data = 16'd0;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_addr_i(mem_addr_i),
    .alu_data_i(alu_data_i), .rd_i(rd_i), .op_i(op_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_o(stall_o), .valid_o(valid_o), .wb_en_o(wb_en_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register-writing ops are all except store, branches and halt.
  function automatic logic exp_wb_en(input logic [3:0] op);
    return !(op inside {4'b1001, 4'b1100, 4'b1101, 4'b1111});
  endfunction

  // Present one instruction, answer memory after `delay` wait cycles, check retirement.
  task automatic do_instr(input logic [3:0] op, input logic [3:0] rd, input logic [15:0] addr,
                          input logic [15:0] data, input int delay, input logic [15:0] rdata);
    logic        mem;
    int          stalls;
    logic [15:0] exp_data;
    mem = (op == LW) || (op == SW);
    stalls = 0;
    @(negedge clk);
    valid_i = 1'b1; op_i = op; rd_i = rd; mem_addr_i = addr; alu_data_i = data; dmem_ack = 1'b0;
    #1;
    if (!mem) begin
      check("alu_stall", 32'(stall_o), 32'd0);
      exp_data = data;
    end else begin
      stalls += int'(stall_o);
      @(posedge clk); #1;
      check("acc_req", 32'(dmem_req), 32'd1);
      check("acc_we", 32'(dmem_we), 32'(op == SW));
      check("acc_addr", 32'(dmem_addr), 32'(addr & 16'hFFFE));
      check("acc_wdata", 32'(dmem_wdata), 32'(data));
      check("acc_valid", 32'(valid_o), 32'd0);
      for (int w = 0; w < delay; w++) begin
        @(negedge clk); #1;
        stalls += int'(stall_o);
        check("wait_addr", 32'(dmem_addr), 32'(addr & 16'hFFFE));
        check("wait_req_valid", {30'd0, dmem_req, valid_o}, 32'd2);
      end
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = rdata;
      #1;
      check("ack_stall", 32'(stall_o), 32'd0);
      check("stall_cycles", 32'(stalls), 32'(delay + 1));
      exp_data = (op == LW) ? rdata : data;
    end
    @(posedge clk); #1;
    valid_i = 1'b0; dmem_ack = 1'b0;
    check("ret_valid", 32'(valid_o), 32'd1);
    check("ret_wb_en", 32'(wb_en_o), 32'(exp_wb_en(op)));
    check("ret_rd", 32'(wb_rd_o), 32'(rd));
    check("ret_data", 32'(wb_data_o), 32'(exp_data));
    check("ret_req_we", {30'd0, dmem_req, dmem_we}, 32'd0);
    last_rd = rd; last_data = exp_data;
  endtask

  // One idle cycle, optionally with a spurious acknowledge: outputs must not move.
  task automatic idle_gap(input logic spurious);
    @(negedge clk);
    valid_i = 1'b0; dmem_ack = spurious; dmem_rdata = 16'($urandom);
    #1;
    check("gap_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("gap_valid", 32'(valid_o), 32'd0);
    check("gap_req", 32'(dmem_req), 32'd0);
    check("gap_rd_hold", 32'(wb_rd_o), 32'(last_rd));
    check("gap_data_hold", 32'(wb_data_o), 32'(last_data));
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {28'd0, dmem_req, dmem_we, valid_o, wb_en_o}, 32'd0);
    check("rst_bus", {dmem_addr, dmem_wdata}, 32'd0);
    check("rst_wb", {12'd0, wb_rd_o, wb_data_o}, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(negedge clk); rst = 1'b0;

    do_instr(ADD, 4'd3, 16'd0, 16'h1234, 0, 16'd0);
    idle_gap(1'b1);
    do_instr(LW, 4'd5, 16'h0041, 16'h0000, 3, 16'hBEEF);
    idle_gap(1'b0);
    do_instr(SW, 4'd2, 16'h0010, 16'h00FF, 0, 16'hAAAA);
    idle_gap(1'b1);
    do_instr(4'b1100, 4'd7, 16'h0000, 16'h5555, 0, 16'd0);
    do_instr(LW, 4'd9, 16'h1233, 16'h0000, 15, 16'hCAFE);

    for (int i = 0; i < 40; i++) begin
      do_instr(4'($urandom_range(0, 15)), 4'($urandom), 16'($urandom), 16'($urandom),
               int'($urandom_range(0, 6)), 16'($urandom));
      if ($urandom_range(0, 1) == 1) idle_gap(1'($urandom));
    end

    // Reset while an access is pending and acknowledged in the same cycle.
    @(negedge clk);
    valid_i = 1'b1; op_i = LW; rd_i = 4'd4; mem_addr_i = 16'h0100; alu_data_i = 16'd0;
    @(posedge clk); #1;
    check("abort_pre_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 16'h7777;
    @(posedge clk); #1;
    check("abort_req", 32'(dmem_req), 32'd0);
    check("abort_valid", 32'(valid_o), 32'd0);
    rst = 1'b0; dmem_ack = 1'b0; valid_i = 1'b0;
    last_rd = 4'd0; last_data = 16'd0;
    @(posedge clk); #1;
    check("abort_after_valid", 32'(valid_o), 32'd0);
    do_instr(ADD, 4'd1, 16'd0, 16'h0F0F, 0, 16'd0);

    // Memory never answers.
    @(negedge clk);
    valid_i = 1'b1; op_i = LW; rd_i = 4'd6; mem_addr_i = 16'h0200; alu_data_i = 16'd0;
    @(posedge clk); #1;
`ifdef MEM_TIMEOUT_EN
    n = 0;
    while (dmem_req && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    check("to_cycles", 32'(n), 32'd16);
    check("to_valid", 32'(valid_o), 32'd1);
    check("to_wb_en", 32'(wb_en_o), 32'd0);
    check("to_err", 32'(err_o), 32'd1);
    do_instr(ADD, 4'd2, 16'd0, 16'h3333, 0, 16'd0);
    check("to_err_sticky", 32'(err_o), 32'd1);
`else
    n = 0;
    repeat (100) @(posedge clk);
    #1;
    check("wait_req_100", 32'(dmem_req), 32'd1);
    check("wait_err_100", 32'(err_o), 32'd0);
    check("wait_stall_100", 32'(stall_o), 32'd1);
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 16'h4242;
    @(posedge clk); #1;
    dmem_ack = 1'b0; valid_i = 1'b0;
    check("late_valid", 32'(valid_o), 32'd1);
    check("late_data", 32'(wb_data_o), 32'h4242);
`endif
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("final_err", 32'(err_o), 32'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
